sram_1rw1r_wmask: RTL and testbench

SRAM_1RW1R_WMASK -- requirements
Module: sram_1rw1r_wmask

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_port_reg.sv | 30 +++
 rtl/sram_1rw1r_wmask.sv | 156 +++++++++++++++
 tb/tb_sram_1rw1r_wmask.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults and operation decode for the 1RW/1R byte-masked SRAM.
package sram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 7;
    localparam int BYTE_W             = 8;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    function automatic op_e decode_op(input logic csb, input logic web);
        if (csb) begin
            return OP_IDLE;
        end
        return web ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/sram_port_reg.sv
// Posedge capture of one port's request bundle, with an async reset value
// chosen by the instantiating port so that reset reads as "deselected".
module sram_port_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cap_d;
    logic [W-1:0] cap_q;

    always_comb begin
        cap_d = d_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= RST_VAL;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign q_o = cap_q;

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Dual-port SRAM: port 0 read/write with byte-lane mask, port 1 read-only.
// Requests are captured on posedge and executed against the array on negedge.
module sram_1rw1r_wmask
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1
);

    localparam int P0_W = 2 + NUM_WMASKS + ADDR_WIDTH + DATA_WIDTH;
    localparam int P1_W = 1 + ADDR_WIDTH;

    // Reset leaves both ports deselected and port 0 in read mode.
    localparam logic [P0_W-1:0]       P0_RST    = {2'b11, {(P0_W - 2){1'b0}}};
    localparam logic [P1_W-1:0]       P1_RST    = {1'b1, {(P1_W - 1){1'b0}}};
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return r;
    endfunction

    logic [P0_W-1:0]       p0_q;
    logic [P1_W-1:0]       p1_q;
    logic                  csb0_q;
    logic                  web0_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  csb1_q;
    logic [ADDR_WIDTH-1:0] addr1_q;

    sram_port_reg #(
        .W       (P0_W),
        .RST_VAL (P0_RST)
    ) u_port0 (
        .clk   (clk0),
        .rst_n (rst0_n),
        .d_i   ({csb0, web0, wmask0, addr0, din0}),
        .q_o   (p0_q)
    );

    sram_port_reg #(
        .W       (P1_W),
        .RST_VAL (P1_RST)
    ) u_port1 (
        .clk   (clk0),
        .rst_n (rst0_n),
        .d_i   ({csb1, addr1}),
        .q_o   (p1_q)
    );

    assign {csb0_q, web0_q, wmask0_q, addr0_q, din0_q} = p0_q;
    assign {csb1_q, addr1_q}                           = p1_q;

    logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

    op_e                   op0;
    logic                  in0;
    logic                  in1;
    logic [DATA_WIDTH-1:0] word0;
    logic [DATA_WIDTH-1:0] word1;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] dout0_d, dout0_q;
    logic [DATA_WIDTH-1:0] dout1_d, dout1_q;
    logic                  dvalid0_d, dvalid0_q;
    logic                  dvalid1_d, dvalid1_q;

    always_comb begin
        op0 = decode_op(csb0_q, web0_q);
        in0 = {1'b0, addr0_q} < DEPTH_LIM;
        in1 = {1'b0, addr1_q} < DEPTH_LIM;

        // Out-of-range addresses read as zero and never reach the array.
        word0 = '0;
        if (in0) begin
            word0 = mem[addr0_q];
        end
        word1 = '0;
        if (in1) begin
            word1 = mem[addr1_q];
        end

        wr_en   = (op0 == OP_WRITE) && in0;
        wr_word = merge_lanes(word0, din0_q, wmask0_q);

        dout0_d   = dout0_q;
        dvalid0_d = 1'b0;
        if (op0 == OP_READ) begin
            dout0_d   = word0;
            dvalid0_d = 1'b1;
        end

        dout1_d   = dout1_q;
        dvalid1_d = 1'b0;
        if (!csb1_q) begin
            dout1_d   = word1;
            dvalid1_d = 1'b1;
        end
    end

    // Port 1 samples the array in the same negedge as the write, so a
    // colliding read sees the pre-write word.
    always_ff @(negedge clk0) begin
        if (wr_en) begin
            mem[addr0_q] <= wr_word;
        end
    end

    always_ff @(negedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            dout0_q   <= '0;
            dout1_q   <= '0;
            dvalid0_q <= 1'b0;
            dvalid1_q <= 1'b0;
        end else begin
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            dvalid0_q <= dvalid0_d;
            dvalid1_q <= dvalid1_d;
        end
    end

    assign dout0   = dout0_q;
    assign dout1   = dout1_q;
    assign dvalid0 = dvalid0_q;
    assign dvalid1 = dvalid1_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Randomized bench for sram_1rw1r_wmask against an array-based reference model.
module tb_sram_1rw1r_wmask;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 100;
    localparam int NM    = DW / 8;

    logic          clk0;
    logic          rst0_n;
    logic          csb0;
    logic          web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          dvalid0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic          dvalid1;

    sram_1rw1r_wmask #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clk0    (clk0),
        .rst0_n  (rst0_n),
        .csb0    (csb0),
        .web0    (web0),
        .wmask0  (wmask0),
        .addr0   (addr0),
        .din0    (din0),
        .dout0   (dout0),
        .dvalid0 (dvalid0),
        .csb1    (csb1),
        .addr1   (addr1),
        .dout1   (dout1),
        .dvalid1 (dvalid1)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int n_vec;
    int n_miss;

    // Reference model state
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] exp_d0;
    logic [DW-1:0] exp_d1;
    logic          exp_v0;
    logic          exp_v1;

    task automatic model_reset();
        exp_d0 = '0;
        exp_d1 = '0;
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
    endtask

    task automatic set_idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
    endtask

    // Apply one request pair for one cycle, then advance the model and leave
    // time just after the executing negedge so outputs can be sampled.
    task automatic step(input logic c0, input logic w0, input logic [NM-1:0] m,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d,
                        input logic c1, input logic [AW-1:0] a1);
        csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
        csb1 = c1; addr1 = a1;
        @(posedge clk0);
        @(negedge clk0);
        #1;
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
        if (!c1) begin
            exp_v1 = 1'b1;
            exp_d1 = (int'(a1) < DEPTH) ? ref_mem[a1] : '0;
        end
        if (!c0 && w0) begin
            exp_v0 = 1'b1;
            exp_d0 = (int'(a0) < DEPTH) ? ref_mem[a0] : '0;
        end
        if (!c0 && !w0 && int'(a0) < DEPTH) begin
            for (int b = 0; b < NM; b++) begin
                if (m[b]) ref_mem[a0][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst0_n = 1'b1;
        #2 rst0_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (dout0 !== '0)   begin n_miss++; $display("FAIL reset_dout0 got %h want 0", dout0); end
        n_vec++; if (dout1 !== '0)   begin n_miss++; $display("FAIL reset_dout1 got %h want 0", dout1); end
        n_vec++; if (dvalid0 !== 1'b0) begin n_miss++; $display("FAIL reset_dvalid0 got %b want 0", dvalid0); end
        n_vec++; if (dvalid1 !== 1'b0) begin n_miss++; $display("FAIL reset_dvalid1 got %b want 0", dvalid1); end
        @(posedge clk0);
        @(posedge clk0);
        #2 rst0_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 1'b0, '1, 7'(a), $urandom, 1'b1, '0);
            n_vec++;
            if (dvalid0 !== 1'b0 || dout0 !== exp_d0) begin
                n_miss++;
                $display("FAIL fill_hold addr=%0d dvalid0=%b dout0=%h want dvalid0=0 dout0=%h", a, dvalid0, dout0, exp_d0);
            end
        end
    endtask

    task automatic test_reset_read();
        #1 rst0_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (dout0 !== '0) begin n_miss++; $display("FAIL rr_in_reset dout0 got %h want 0", dout0); end
        rst0_n = 1'b1;
        step(1'b0, 1'b1, '0, 7'd5, '0, 1'b1, '0);
        n_vec++; if (dvalid0 !== 1'b1) begin n_miss++; $display("FAIL rr_dvalid0 got %b want 1", dvalid0); end
        n_vec++; if (dout0 !== exp_d0) begin n_miss++; $display("FAIL rr_dout0 addr5 got %h want %h", dout0, exp_d0); end
        step(1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
        n_vec++; if (dvalid0 !== 1'b0) begin n_miss++; $display("FAIL rr_pulse dvalid0 got %b want 0", dvalid0); end
        n_vec++; if (dout0 !== exp_d0) begin n_miss++; $display("FAIL rr_hold dout0 got %h want %h", dout0, exp_d0); end
    endtask

    task automatic test_wmask();
        step(1'b0, 1'b0, 4'b1111, 7'd3, 32'hDEADBEEF, 1'b1, '0);
        step(1'b0, 1'b0, 4'b0101, 7'd3, 32'h11223344, 1'b1, '0);
        step(1'b0, 1'b1, '0, 7'd3, '0, 1'b1, '0);
        n_vec++; if (dout0 !== 32'hDE22BE44) begin n_miss++; $display("FAIL wmask_merge got %h want de22be44", dout0); end
        step(1'b0, 1'b0, 4'b0000, 7'd3, 32'h0BADF00D, 1'b1, '0);
        step(1'b0, 1'b1, '0, 7'd3, '0, 1'b1, '0);
        n_vec++; if (dout0 !== 32'hDE22BE44) begin n_miss++; $display("FAIL wmask_zero got %h want de22be44", dout0); end
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = 7'($urandom_range(0, DEPTH - 1));
            step(1'b0, 1'b0, 4'($urandom), a, $urandom, 1'b1, '0);
            step(1'b0, 1'b1, '0, a, '0, 1'b1, '0);
            n_vec++;
            if (dout0 !== exp_d0) begin n_miss++; $display("FAIL wmask_rand addr=%0d got %h want %h", a, dout0, exp_d0); end
        end
    endtask

    task automatic test_collision();
        step(1'b0, 1'b0, '1, 7'd9, 32'h0, 1'b1, '0);
        step(1'b0, 1'b0, '1, 7'd9, 32'hA5A5A5A5, 1'b0, 7'd9);
        n_vec++; if (dout1 !== 32'h0) begin n_miss++; $display("FAIL collide_old got %h want 0", dout1); end
        n_vec++; if (dvalid1 !== 1'b1) begin n_miss++; $display("FAIL collide_dvalid1 got %b want 1", dvalid1); end
        step(1'b1, 1'b1, '0, '0, '0, 1'b0, 7'd9);
        n_vec++; if (dout1 !== 32'hA5A5A5A5) begin n_miss++; $display("FAIL collide_new got %h want a5a5a5a5", dout1); end
    endtask

    task automatic test_out_of_range();
        step(1'b0, 1'b0, '1, 7'd120, 32'hFFFFFFFF, 1'b1, '0);
        step(1'b0, 1'b1, '0, 7'd120, '0, 1'b0, 7'd120);
        n_vec++; if (dout0 !== '0) begin n_miss++; $display("FAIL oor_dout0 got %h want 0", dout0); end
        n_vec++; if (dvalid0 !== 1'b1) begin n_miss++; $display("FAIL oor_dvalid0 got %b want 1", dvalid0); end
        n_vec++; if (dout1 !== '0 || dvalid1 !== 1'b1) begin n_miss++; $display("FAIL oor_port1 got %h/%b want 0/1", dout1, dvalid1); end
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 1'b1, '0, '0, '0, 1'b0, 7'(a));
            n_vec++;
            if (dout1 !== exp_d1) begin n_miss++; $display("FAIL oor_intact addr=%0d got %h want %h", a, dout1, exp_d1); end
        end
    endtask

    task automatic test_reset_cancel();
        step(1'b0, 1'b1, '0, 7'd3, '0, 1'b1, '0);
        csb0 = 1'b0; web0 = 1'b0; wmask0 = '1; addr0 = 7'd7; din0 = 32'h12345678;
        @(posedge clk0);
        #2 rst0_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (dout0 !== '0) begin n_miss++; $display("FAIL cancel_in_reset dout0 got %h want 0", dout0); end
        set_idle();
        #1 rst0_n = 1'b1;
        @(negedge clk0);
        #1;
        n_vec++; if (dout0 !== '0)     begin n_miss++; $display("FAIL cancel_dout0 got %h want 0", dout0); end
        n_vec++; if (dvalid0 !== 1'b0) begin n_miss++; $display("FAIL cancel_dvalid0 got %b want 0", dvalid0); end
        step(1'b0, 1'b1, '0, 7'd7, '0, 1'b1, '0);
        n_vec++; if (dout0 !== exp_d0) begin n_miss++; $display("FAIL cancel_mem7 got %h want %h", dout0, exp_d0); end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 128; a++) begin
            step(1'b0, 1'b1, '0, 7'(a), '0, 1'b0, 7'(127 - a));
            n_vec++; if (dvalid0 !== 1'b1) begin n_miss++; $display("FAIL b2b_dvalid0 addr=%0d got %b want 1", a, dvalid0); end
            n_vec++; if (dvalid1 !== 1'b1) begin n_miss++; $display("FAIL b2b_dvalid1 addr=%0d got %b want 1", 127 - a, dvalid1); end
            n_vec++; if (dout0 !== exp_d0) begin n_miss++; $display("FAIL b2b_dout0 addr=%0d got %h want %h", a, dout0, exp_d0); end
            n_vec++; if (dout1 !== exp_d1) begin n_miss++; $display("FAIL b2b_dout1 addr=%0d got %h want %h", 127 - a, dout1, exp_d1); end
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 400; i++) begin
            logic c0;
            logic c1;
            c0 = ($urandom_range(0, 4) == 0);
            c1 = ($urandom_range(0, 3) == 0);
            step(c0, 1'($urandom), 4'($urandom), 7'($urandom_range(0, 127)), $urandom,
                 c1, 7'($urandom_range(0, 127)));
            n_vec++;
            if (dout0 !== exp_d0 || dvalid0 !== exp_v0) begin
                n_miss++;
                $display("FAIL mix_port0 cycle=%0d got %h/%b want %h/%b", i, dout0, dvalid0, exp_d0, exp_v0);
            end
            n_vec++;
            if (dout1 !== exp_d1 || dvalid1 !== exp_v1) begin
                n_miss++;
                $display("FAIL mix_port1 cycle=%0d got %h/%b want %h/%b", i, dout1, dvalid1, exp_d1, exp_v1);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_fill();
        test_reset_read();
        test_wmask();
        test_collision();
        test_out_of_range();
        test_reset_cancel();
        test_back_to_back();
        test_random_mix();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
